// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: state encoding and byte-path constants.
package uart_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SEND = 2'd1;
  localparam state_t ST_WAIT = 2'd2;

  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned DEF_TIMEOUT_CYC = 4096;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first valid index at or after ptr, wrapping.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [2:0]         i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [2:0]         o_idx,
  output logic               o_any
);

  int unsigned w_best;

  // Winner is the valid requester with the smallest circular distance from ptr.
  always_comb begin
    w_best = NUM_REQ;
    o_idx  = 3'd0;
    o_any  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (i_valid[i] && (((i + NUM_REQ - 32'(i_ptr)) % NUM_REQ) < w_best)) begin
        w_best = (i + NUM_REQ - 32'(i_ptr)) % NUM_REQ;
        o_idx  = 3'(i);
        o_any  = 1'b1;
      end
    end
  end

  always_comb begin
    o_grant = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      o_grant[i] = o_any && (o_idx == 3'(i));
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters,
// with a per-transfer completion timeout and a completed-byte counter.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]         tx_data,
  output logic                      tx_start,
  input  logic                      tx_busy,
  input  logic                      tx_done,
  output logic [2:0]                grant_id,
  output logic                      active,
  output logic                      timeout_err,
  input  logic                      err_clr,
  output logic [15:0]               sent_cnt
);

  state_t              r_state;
  logic [2:0]          r_ptr;
  logic [2:0]          r_grant_id;
  logic [BYTE_W-1:0]   r_tx_data;
  logic [15:0]         r_timer;
  logic                r_timeout_err;
  logic [15:0]         r_sent_cnt;

  logic [NUM_REQ-1:0]  w_pick_grant;
  logic [2:0]          w_pick_idx;
  logic                w_pick_any;
  logic [BYTE_W-1:0]   w_pick_data;
  logic                w_accept;
  logic                w_timeout;
  logic [2:0]          w_next_ptr;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  always_comb begin
    w_pick_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_pick_grant[i]) begin
        w_pick_data = req_data[BYTE_W*i +: BYTE_W];
      end
    end
  end

  // A busy transmitter blocks arbitration entirely; valids are only looked at in IDLE.
  assign w_accept   = (r_state == ST_IDLE) && w_pick_any && !tx_busy;
  assign w_timeout  = (r_state == ST_WAIT) && !tx_done && (r_timer == 16'(TIMEOUT_CYC - 1));
  assign w_next_ptr = ((32'(r_grant_id) + 32'd1) >= NUM_REQ) ? 3'd0 : r_grant_id + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= 3'd0;
      r_grant_id <= 3'd0;
      r_tx_data  <= '0;
      r_timer    <= 16'd0;
      r_sent_cnt <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state    <= ST_SEND;
            r_tx_data  <= w_pick_data;
            r_grant_id <= w_pick_idx;
          end
        end
        ST_SEND: begin
          r_state <= ST_WAIT;
          r_timer <= 16'd0;
        end
        ST_WAIT: begin
          if (tx_done) begin
            r_state    <= ST_IDLE;
            r_sent_cnt <= r_sent_cnt + 16'd1;
            r_ptr      <= w_next_ptr;
          end else if (w_timeout) begin
            r_state <= ST_IDLE;
            r_ptr   <= w_next_ptr;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A timeout in the same cycle as err_clr wins so the event is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timeout_err <= 1'b0;
    end else if (w_timeout) begin
      r_timeout_err <= 1'b1;
    end else if (err_clr) begin
      r_timeout_err <= 1'b0;
    end
  end

  assign req_ready   = w_accept ? w_pick_grant : '0;
  assign tx_start    = (r_state == ST_SEND);
  assign tx_data     = r_tx_data;
  assign grant_id    = r_grant_id;
  assign active      = (r_state != ST_IDLE);
  assign timeout_err = r_timeout_err;
  assign sent_cnt    = r_sent_cnt;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized transfers
// scored against a transaction-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*8-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_start;
  logic           tx_busy = 1'b0;
  logic           tx_done = 1'b0;
  logic [2:0]     grant_id;
  logic           active;
  logic           timeout_err;
  logic           err_clr = 1'b0;
  logic [15:0]    sent_cnt;

  int   total = 0;
  int   bad   = 0;
  int   m_ptr = 0;
  int   m_sent = 0;
  logic m_err = 1'b0;

  uart_tx_arbiter #(
    .NUM_REQ     (N),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .active      (active),
    .timeout_err (timeout_err),
    .err_clr     (err_clr),
    .sent_cnt    (sent_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Spec rule: first valid requester scanning ptr, ptr+1, ... modulo N.
  function automatic int pick(input logic [N-1:0] mask, input int ptr);
    for (int k = 0; k < int'(N); k++) begin
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  task automatic check_idle_state(input string tag);
    check_eq({tag, "_active"}, 32'(active), 32'd0);
    check_eq({tag, "_start"}, 32'(tx_start), 32'd0);
    check_eq({tag, "_sent"}, 32'(sent_cnt), 32'(m_sent));
    check_eq({tag, "_err"}, 32'(timeout_err), 32'(m_err));
  endtask

  // One full transfer; d is the number of quiet WAIT cycles before tx_done.
  task automatic xfer(input logic [N-1:0] mask, input logic [N*8-1:0] data, input int busy_cyc,
                      input bit is_timeout, input int d, input bit coin_done, input bit coin_clr);
    int w;
    req_data  = data;
    req_valid = mask;
    tx_busy   = (busy_cyc > 0);
    for (int i = 0; i < busy_cyc; i++) begin
      #1;
      check_eq("busy_ready", 32'(req_ready), 32'd0);
      check_eq("busy_start", 32'(tx_start), 32'd0);
      step();
    end
    tx_busy = 1'b0;
    #1;
    w = pick(mask, m_ptr);
    check_eq("accept_ready", 32'(req_ready), 32'(1 << w));
    check_eq("accept_idle", 32'(active), 32'd0);
    step();
    req_valid = '0;
    tx_done   = coin_done;
    #1;
    check_eq("send_start", 32'(tx_start), 32'd1);
    check_eq("send_data", 32'(tx_data), 32'(data[w*8 +: 8]));
    check_eq("send_gid", 32'(grant_id), 32'(w));
    check_eq("send_ready", 32'(req_ready), 32'd0);
    step();
    tx_done = 1'b0;
    m_ptr   = (w + 1) % N;
    if (is_timeout) begin
      for (int k = 1; k <= int'(TO); k++) begin
        check_eq("to_wait_active", 32'(active), 32'd1);
        check_eq("to_wait_err", 32'(timeout_err), 32'(m_err));
        if (k == int'(TO)) err_clr = coin_clr;
        step();
      end
      err_clr = 1'b0;
      m_err   = 1'b1;
    end else begin
      for (int k = 0; k < d; k++) begin
        check_eq("wait_active", 32'(active), 32'd1);
        check_eq("wait_start", 32'(tx_start), 32'd0);
        step();
      end
      tx_done = 1'b1;
      step();
      tx_done = 1'b0;
      m_sent  = (m_sent + 1) % 65536;
    end
    check_idle_state("post");
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    m_err   = 1'b0;
    check_eq("clr_err", 32'(timeout_err), 32'd0);
  endtask

  initial begin
    logic [N*8-1:0] dat;
    rst = 1'b1;
    step();
    step();
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_data", 32'(tx_data), 32'd0);
    check_eq("rst_gid", 32'(grant_id), 32'd0);
    check_idle_state("rst");
    rst = 1'b0;
    step();

    // Full contention from ptr 0: grants must rotate 0,1,2,3,0.
    for (int t = 0; t < 5; t++) begin
      xfer(4'hF, $urandom, 0, 1'b0, 9, 1'b0, 1'b0);
    end

    // Lone requester 2 with 0x65, then full contention must start at 3.
    dat = $urandom;
    dat[23:16] = 8'h65;
    xfer(4'b0100, dat, 0, 1'b0, 4, 1'b0, 1'b0);
    check_eq("sent_after_single", 32'(sent_cnt), 32'd6);
    xfer(4'hF, $urandom, 0, 1'b0, 2, 1'b1, 1'b0);

    // Busy transmitter blocks grants for 20 cycles.
    xfer(4'b0010, $urandom, 20, 1'b0, 0, 1'b0, 1'b0);

    // Timeouts: coincident err_clr must not clear the new error.
    xfer(4'hF, $urandom, 0, 1'b1, 0, 1'b0, 1'b0);
    check_eq("to_err_set", 32'(timeout_err), 32'd1);
    xfer(4'hF, $urandom, 0, 1'b1, 0, 1'b1, 1'b1);
    check_eq("to_err_coinc", 32'(timeout_err), 32'd1);
    clr_err();

    for (int t = 0; t < 60; t++) begin
      xfer(N'($urandom_range(1, (1 << N) - 1)), $urandom, $urandom_range(0, 3),
           ($urandom_range(0, 3) == 0), $urandom_range(0, TO - 1),
           $urandom_range(0, 1), $urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) clr_err();
    end

    // Reset in the middle of WAIT aborts the transfer.
    req_data  = $urandom;
    req_valid = 4'b1000;
    step();
    req_valid = '0;
    step();
    step();
    step();
    check_eq("pre_rst_active", 32'(active), 32'd1);
    rst = 1'b1;
    step();
    rst    = 1'b0;
    m_ptr  = 0;
    m_sent = 0;
    m_err  = 1'b0;
    check_eq("wrst_data", 32'(tx_data), 32'd0);
    check_eq("wrst_gid", 32'(grant_id), 32'd0);
    check_idle_state("wrst");
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check_idle_state("wrst_done");
    step();
    check_eq("wrst_nostart", 32'(tx_start), 32'd0);
    xfer(4'b0011, $urandom, 0, 1'b0, 3, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of byte requesters sharing one UART transmitter (legal range 2..8).
REQ-002 Parameter TIMEOUT_CYC, default 4096, WAIT-state cycle limit before a transfer is abandoned.
REQ-003 Port clk  input  1  clock; all logic on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port req_valid  input  NUM_REQ  per-requester byte-available flag, level, held until accepted.
REQ-006 Port req_data  input  NUM_REQ*8  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-007 Port req_ready  output  NUM_REQ  one-hot acceptance strobe, one cycle, to the granted requester.
REQ-008 Port tx_data  output  8  byte driven to the UART transmitter data input.
REQ-009 Port tx_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-010 Port tx_busy  input  1  transmitter busy (start bit through stop bit).
REQ-011 Port tx_done  input  1  transmitter one-cycle completion pulse.
REQ-012 Port grant_id  output  3  index of the current or last granted requester.
REQ-013 Port active  output  1  high in every state except IDLE.
REQ-014 Port timeout_err  output  1  sticky timeout flag.
REQ-015 Port err_clr  input  1  clears timeout_err.
REQ-016 Port sent_cnt  output  16  count of bytes completed with tx_done; wraps 0xFFFF->0x0000.

Function
REQ-017 FSM states: IDLE, SEND, WAIT; encoding comes from the shared package.
REQ-018 IDLE: when any req_valid is high and tx_busy is low, winner = first valid index searching ptr, ptr+1, ..., wrapping modulo NUM_REQ.
REQ-019 Accept cycle: req_ready[winner] high combinationally in that cycle only; tx_data and grant_id register req_data[winner] and winner; next state SEND.
REQ-020 SEND: tx_start high for exactly this one cycle, tx_data stable; next state WAIT.
REQ-021 Latency: req_valid sampled in IDLE at cycle n gives req_ready at n, tx_start at n+1.
REQ-022 WAIT: on tx_done go to IDLE, increment sent_cnt, set ptr = (grant_id+1) mod NUM_REQ.
REQ-023 WAIT: 16-bit timer counts from 0 on entry; on reaching TIMEOUT_CYC-1 without tx_done, set timeout_err, advance ptr as in REQ-022, go to IDLE, leave sent_cnt unchanged.
REQ-024 tx_done outside WAIT, including coincident with tx_start, is ignored.
REQ-025 tx_busy high in IDLE blocks all grants; no req_ready is asserted.
REQ-026 tx_data holds the last transmitted byte between transfers.
REQ-027 No requester gets a second grant while any other valid requester is waiting; the worst-case wait is NUM_REQ-1 transfers.
REQ-028 err_clr and timeout in the same cycle: timeout_err stays set.
REQ-029 A requester deasserting req_valid before acceptance is legal; the arbiter only evaluates req_valid in IDLE.

Reset
REQ-030 On rst: state IDLE, ptr 0, grant_id 0, tx_data 0x00, tx_start 0, req_ready 0, active 0, timeout_err 0, sent_cnt 0, timer 0.
REQ-031 Reset in SEND or WAIT aborts the transfer with no tx_start issued afterwards and no sent_cnt change; reset has priority over every other input.

Structure
REQ-032 Shared package uart_pkg holds the FSM state typedef, the byte width constant (8) and the default TIMEOUT_CYC.
REQ-033 One sub-module, rr_picker, takes valid and ptr and produces a one-hot grant plus an encoded index; it is purely combinational.

Verification
REQ-034 Single requester: req_valid[2]=1, req_data[2]=0x65 in IDLE -> req_ready[2] pulses at n, tx_start at n+1 with tx_data=0x65; tx_done -> sent_cnt=1, ptr=3.
REQ-035 All four valid, ptr=0, tx_done 10 cycles after each tx_start -> grant order 0,1,2,3,0, each with exactly one req_ready.
REQ-036 No tx_done after tx_start with TIMEOUT_CYC=16 -> timeout_err=1 on the 16th WAIT cycle, then IDLE, sent_cnt unchanged, next grant goes to the following index.
REQ-037 tx_busy=1 held 20 cycles with req_valid[1]=1 -> no req_ready and no tx_start; grant in the first cycle after tx_busy falls.
REQ-038 rst asserted in WAIT -> all outputs at reset values the next cycle; a later tx_done does not increment sent_cnt.
REQ-039 err_clr coincident with a second timeout -> timeout_err remains 1; err_clr alone a cycle later -> 0.
